reg_ctrl_sequencer: RTL and testbench

- Multi-cycle control sequencer sitting directly upstream of the 4x10-bit register file.
- Accepts one 10-bit instruction per handshake, decodes it, and steps through timesteps. Drives the register-file read/write enables and addresses, the ALU operand latches and op select, and the external/immediate bus output enables.
- Signals completion with a one-cycle DONE pulse.

---
 rtl/reg_ctrl_sequencer_pkg.sv | 86 ++++++++
 rtl/reg_ctrl_decode.sv | 71 +++++++
 rtl/reg_ctrl_sequencer.sv | 83 ++++++++
 tb/tb_reg_ctrl_sequencer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/reg_ctrl_sequencer_pkg.sv
// Shared types and constants for the register-file control sequencer.
// The instruction layout, opcode map, ALU selects and the decoded control bundle are defined here.
package reg_ctrl_sequencer_pkg;

    localparam int DW = 10;
    localparam int AW = 2;

    localparam int OPC_HI = 9;
    localparam int OPC_LO = 6;
    localparam int RX_HI  = 5;
    localparam int RX_LO  = 4;
    localparam int RY_HI  = 3;
    localparam int RY_LO  = 2;
    localparam int IMM_HI = 3;
    localparam int IMM_LO = 0;

    typedef enum logic [3:0] {
        OP_LOAD = 4'h0,
        OP_MOV  = 4'h1,
        OP_ADD  = 4'h2,
        OP_SUB  = 4'h3,
        OP_AND  = 4'h4,
        OP_OR   = 4'h5,
        OP_XOR  = 4'h6,
        OP_NOT  = 4'h7,
        OP_ADDI = 4'h8,
        OP_SUBI = 4'h9
    } opcode_e;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_NOT = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_X1   = 3'd1,
        S_T1   = 3'd2,
        S_T2   = 3'd3,
        S_T3   = 3'd4,
        S_ERR  = 3'd5
    } state_e;

    typedef struct packed {
        logic          instr_ready;
        logic          enw;
        logic [AW-1:0] wra;
        logic          enr0;
        logic          enr1;
        logic [AW-1:0] rda0;
        logic [AW-1:0] rda1;
        logic          a_ld;
        logic          g_ld;
        logic          g_oe;
        logic          ext_oe;
        logic          imm_oe;
        logic [DW-1:0] imm;
        logic [2:0]    alu_op;
        logic          done;
        logic          illegal;
    } ctrl_t;

    function automatic logic [2:0] alu_sel(input logic [3:0] opc);
        case (opc)
            OP_ADD, OP_ADDI: alu_sel = ALU_ADD;
            OP_SUB, OP_SUBI: alu_sel = ALU_SUB;
            OP_AND:          alu_sel = ALU_AND;
            OP_OR:           alu_sel = ALU_OR;
            OP_XOR:          alu_sel = ALU_XOR;
            OP_NOT:          alu_sel = ALU_NOT;
            default:         alu_sel = ALU_ADD;
        endcase
    endfunction

    function automatic state_e first_state(input logic [3:0] opc);
        if (opc == OP_LOAD || opc == OP_MOV)
            first_state = S_X1;
        else if (opc <= OP_SUBI)
            first_state = S_T1;
        else
            first_state = S_ERR;
    endfunction

endpackage

// File: rtl/reg_ctrl_decode.sv
// Pure Moore decode of {state, IR} into the register-file / ALU control bundle.
// Unknown state encodings decode like IDLE: ready, no enables.
module reg_ctrl_decode
    import reg_ctrl_sequencer_pkg::*;
(
    input  state_e        state_i,
    input  logic [DW-1:0] ir_i,
    output ctrl_t         ctrl_o
);

    logic [3:0]    opc;
    logic [AW-1:0] rx;
    logic [AW-1:0] ry;
    logic [3:0]    imm4;
    logic          imm_op;

    assign opc    = ir_i[OPC_HI:OPC_LO];
    assign rx     = ir_i[RX_HI:RX_LO];
    assign ry     = ir_i[RY_HI:RY_LO];
    assign imm4   = ir_i[IMM_HI:IMM_LO];
    assign imm_op = (opc == OP_ADDI) || (opc == OP_SUBI);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_IDLE: ctrl_o.instr_ready = 1'b1;
            S_X1: begin
                ctrl_o.enw  = 1'b1;
                ctrl_o.wra  = rx;
                ctrl_o.done = 1'b1;
                // MOV relies on the D mux falling back to Q0 with no bus driver enabled
                if (opc == OP_LOAD) begin
                    ctrl_o.ext_oe = 1'b1;
                end else begin
                    ctrl_o.enr0 = 1'b1;
                    ctrl_o.rda0 = ry;
                end
            end
            S_T1: begin
                ctrl_o.enr0   = 1'b1;
                ctrl_o.rda0   = (opc == OP_NOT) ? ry : rx;
                ctrl_o.a_ld   = 1'b1;
                ctrl_o.alu_op = alu_sel(opc);
            end
            S_T2: begin
                ctrl_o.g_ld   = 1'b1;
                ctrl_o.alu_op = alu_sel(opc);
                if (imm_op) begin
                    ctrl_o.imm_oe = 1'b1;
                    ctrl_o.imm    = {{(DW-4){1'b0}}, imm4};
                end else begin
                    ctrl_o.enr1 = 1'b1;
                    ctrl_o.rda1 = ry;
                end
            end
            S_T3: begin
                ctrl_o.g_oe   = 1'b1;
                ctrl_o.enw    = 1'b1;
                ctrl_o.wra    = rx;
                ctrl_o.done   = 1'b1;
                ctrl_o.alu_op = alu_sel(opc);
            end
            S_ERR: begin
                ctrl_o.done    = 1'b1;
                ctrl_o.illegal = 1'b1;
            end
            default: ctrl_o.instr_ready = 1'b1;
        endcase
    end

endmodule

// File: rtl/reg_ctrl_sequencer.sv
// Multi-cycle sequencer driving the 4x10 register file and ALU latches; holds IR and state.
// LOAD/MOV/illegal finish 1 cycle after accept, ALU ops 3; a new instruction is taken only in IDLE.
module reg_ctrl_sequencer
    import reg_ctrl_sequencer_pkg::*;
#(
    parameter int DW_P = DW,
    parameter int NREG = 4
) (
    input  logic                    CLKb,
    input  logic                    RSTb,
    input  logic [DW_P-1:0]         INSTR,
    input  logic                    INSTR_VALID,
    output logic                    INSTR_READY,
    output logic                    ENW,
    output logic [$clog2(NREG)-1:0] WRA,
    output logic                    ENR0,
    output logic                    ENR1,
    output logic [$clog2(NREG)-1:0] RDA0,
    output logic [$clog2(NREG)-1:0] RDA1,
    output logic                    A_LD,
    output logic                    G_LD,
    output logic                    G_OE,
    output logic                    EXT_OE,
    output logic                    IMM_OE,
    output logic [DW_P-1:0]         IMM,
    output logic [2:0]              ALU_OP,
    output logic                    DONE,
    output logic                    ILLEGAL
);

    state_e        state_q;
    logic [DW-1:0] ir_q;
    ctrl_t         ctrl;

    // Async reset forces IDLE, so every enable (ENW included) drops without waiting for a clock
    always_ff @(posedge CLKb or negedge RSTb) begin
        if (!RSTb) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
        end else begin
            case (state_q)
                S_X1, S_T3, S_ERR: state_q <= S_IDLE;
                S_T1:              state_q <= S_T2;
                S_T2:              state_q <= S_T3;
                default: begin
                    if (INSTR_VALID) begin
                        ir_q    <= INSTR;
                        state_q <= first_state(INSTR[OPC_HI:OPC_LO]);
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
            endcase
        end
    end

    reg_ctrl_decode u_decode (
        .state_i (state_q),
        .ir_i    (ir_q),
        .ctrl_o  (ctrl)
    );

    assign INSTR_READY = ctrl.instr_ready;
    assign ENW         = ctrl.enw;
    assign WRA         = ctrl.wra;
    assign ENR0        = ctrl.enr0;
    assign ENR1        = ctrl.enr1;
    assign RDA0        = ctrl.rda0;
    assign RDA1        = ctrl.rda1;
    assign A_LD        = ctrl.a_ld;
    assign G_LD        = ctrl.g_ld;
    assign G_OE        = ctrl.g_oe;
    assign EXT_OE      = ctrl.ext_oe;
    assign IMM_OE      = ctrl.imm_oe;
    assign IMM         = ctrl.imm;
    assign ALU_OP      = ctrl.alu_op;
    assign DONE        = ctrl.done;
    assign ILLEGAL     = ctrl.illegal;

    bus_drv_onehot: assert property (@(posedge CLKb) disable iff (!RSTb)
        $onehot0({EXT_OE, G_OE, IMM_OE}));

endmodule

// File: tb/tb_reg_ctrl_sequencer.sv
// Directed bench for reg_ctrl_sequencer: hand-computed control vectors per state.
// Outputs are sampled on the falling edge; inputs change there too.
module tb_reg_ctrl_sequencer;

    typedef struct packed {
        logic       ready;
        logic       enw;
        logic [1:0] wra;
        logic       enr0;
        logic       enr1;
        logic [1:0] rda0;
        logic [1:0] rda1;
        logic       a_ld;
        logic       g_ld;
        logic       g_oe;
        logic       ext_oe;
        logic       imm_oe;
        logic [9:0] imm;
        logic [2:0] alu;
        logic       done;
        logic       ill;
    } ctl_t;

    logic       CLKb = 1'b0;
    logic       RSTb = 1'b0;
    logic [9:0] INSTR = '0;
    logic       INSTR_VALID = 1'b0;
    logic       INSTR_READY, ENW, ENR0, ENR1, A_LD, G_LD, G_OE, EXT_OE, IMM_OE, DONE, ILLEGAL;
    logic [1:0] WRA, RDA0, RDA1;
    logic [9:0] IMM;
    logic [2:0] ALU_OP;

    int errors = 0;
    int checks = 0;
    int enw_cnt = 0;
    ctl_t e;

    reg_ctrl_sequencer dut (
        .CLKb(CLKb), .RSTb(RSTb), .INSTR(INSTR), .INSTR_VALID(INSTR_VALID),
        .INSTR_READY(INSTR_READY), .ENW(ENW), .WRA(WRA), .ENR0(ENR0), .ENR1(ENR1),
        .RDA0(RDA0), .RDA1(RDA1), .A_LD(A_LD), .G_LD(G_LD), .G_OE(G_OE),
        .EXT_OE(EXT_OE), .IMM_OE(IMM_OE), .IMM(IMM), .ALU_OP(ALU_OP),
        .DONE(DONE), .ILLEGAL(ILLEGAL)
    );

    always #5 CLKb = ~CLKb;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic ctl_t obs();
        ctl_t o;
        o = {INSTR_READY, ENW, WRA, ENR0, ENR1, RDA0, RDA1, A_LD, G_LD, G_OE,
             EXT_OE, IMM_OE, IMM, ALU_OP, DONE, ILLEGAL};
        return o;
    endfunction

    function automatic ctl_t rdy();
        ctl_t r;
        r = '0;
        r.ready = 1'b1;
        return r;
    endfunction

    task automatic step();
        @(negedge CLKb);
    endtask

    // Called on a falling edge while idle; returns on the falling edge of the first step.
    task automatic issue(input logic [9:0] w);
        INSTR = w;
        INSTR_VALID = 1'b1;
        @(negedge CLKb);
        INSTR_VALID = 1'b0;
    endtask

    always @(negedge CLKb)
        if (RSTb) chk_eq("oe_mutex", 32'($countones({EXT_OE, G_OE, IMM_OE}) <= 1), 32'd1);

    always @(posedge CLKb)
        if (ENW) enw_cnt++;

    initial begin
        #1 chk_eq("reset", 32'(obs()), 32'(rdy()));
        @(negedge CLKb);
        RSTb = 1'b1;
        step(); chk_eq("reset_release", 32'(obs()), 32'(rdy()));

        // LOAD R3
        issue(10'b0000_11_00_00);
        e = '0; e.ext_oe = 1; e.enw = 1; e.wra = 2'd3; e.done = 1;
        chk_eq("load_x1", 32'(obs()), 32'(e));
        step(); chk_eq("load_idle", 32'(obs()), 32'(rdy()));

        // ADD R0,R1 with VALID held high carrying LOAD R2 during T1-T3
        INSTR = 10'b0010_00_01_00; INSTR_VALID = 1'b1;
        step();
        e = '0; e.enr0 = 1; e.rda0 = 2'd0; e.a_ld = 1; e.alu = 3'b000;
        chk_eq("add_t1", 32'(obs()), 32'(e));
        INSTR = 10'b0000_10_00_00;
        step();
        e = '0; e.enr1 = 1; e.rda1 = 2'd1; e.g_ld = 1; e.alu = 3'b000;
        chk_eq("add_t2", 32'(obs()), 32'(e));
        step();
        e = '0; e.g_oe = 1; e.enw = 1; e.wra = 2'd0; e.done = 1; e.alu = 3'b000;
        chk_eq("add_t3", 32'(obs()), 32'(e));
        step(); chk_eq("hold_idle", 32'(obs()), 32'(rdy()));
        step();
        e = '0; e.ext_oe = 1; e.enw = 1; e.wra = 2'd2; e.done = 1;
        chk_eq("hold_load_x1", 32'(obs()), 32'(e));
        INSTR_VALID = 1'b0;
        step(); chk_eq("hold_load_idle", 32'(obs()), 32'(rdy()));

        // ADDI R2,#15
        issue(10'b1000_10_11_11);
        e = '0; e.enr0 = 1; e.rda0 = 2'd2; e.a_ld = 1; e.alu = 3'b000;
        chk_eq("addi_t1", 32'(obs()), 32'(e));
        step();
        e = '0; e.imm_oe = 1; e.imm = 10'd15; e.g_ld = 1; e.alu = 3'b000;
        chk_eq("addi_t2", 32'(obs()), 32'(e));
        step();
        e = '0; e.g_oe = 1; e.enw = 1; e.wra = 2'd2; e.done = 1; e.alu = 3'b000;
        chk_eq("addi_t3", 32'(obs()), 32'(e));
        step();

        // SUB R3,R0
        issue(10'b0011_11_00_00);
        step();
        e = '0; e.enr1 = 1; e.rda1 = 2'd0; e.g_ld = 1; e.alu = 3'b001;
        chk_eq("sub_t2", 32'(obs()), 32'(e));
        step(); step();

        // NOT R1,R2: operand A comes from Ry
        issue(10'b0111_01_10_00);
        e = '0; e.enr0 = 1; e.rda0 = 2'd2; e.a_ld = 1; e.alu = 3'b101;
        chk_eq("not_t1", 32'(obs()), 32'(e));
        step(); step();
        e = '0; e.g_oe = 1; e.enw = 1; e.wra = 2'd1; e.done = 1; e.alu = 3'b101;
        chk_eq("not_t3", 32'(obs()), 32'(e));
        step();

        // XOR R2,R3
        issue(10'b0110_10_11_00);
        step();
        e = '0; e.enr1 = 1; e.rda1 = 2'd3; e.g_ld = 1; e.alu = 3'b100;
        chk_eq("xor_t2", 32'(obs()), 32'(e));
        step(); step();

        // SUBI R1,#9
        issue(10'b1001_01_10_01);
        step();
        e = '0; e.imm_oe = 1; e.imm = 10'd9; e.g_ld = 1; e.alu = 3'b001;
        chk_eq("subi_t2", 32'(obs()), 32'(e));
        step(); step();

        // MOV R0,R3
        issue(10'b0001_00_11_00);
        e = '0; e.enr0 = 1; e.rda0 = 2'd3; e.enw = 1; e.wra = 2'd0; e.done = 1;
        chk_eq("mov_x1", 32'(obs()), 32'(e));
        step();

        // Reserved opcode 1100
        issue(10'b1100_01_01_00);
        e = '0; e.done = 1; e.ill = 1;
        chk_eq("illegal_err", 32'(obs()), 32'(e));
        step(); chk_eq("illegal_idle", 32'(obs()), 32'(rdy()));

        // ADD R1,R2 aborted by reset in the middle of T2
        enw_cnt = 0;
        issue(10'b0010_01_10_00);
        e = '0; e.enr0 = 1; e.rda0 = 2'd1; e.a_ld = 1; e.alu = 3'b000;
        chk_eq("abort_t1", 32'(obs()), 32'(e));
        @(posedge CLKb); #2;
        e = '0; e.enr1 = 1; e.rda1 = 2'd2; e.g_ld = 1; e.alu = 3'b000;
        chk_eq("abort_t2", 32'(obs()), 32'(e));
        RSTb = 1'b0;
        #1 chk_eq("abort_async", 32'(obs()), 32'(rdy()));
        @(negedge CLKb);
        RSTb = 1'b1;
        step(); chk_eq("abort_idle0", 32'(obs()), 32'(rdy()));
        step(); chk_eq("abort_idle1", 32'(obs()), 32'(rdy()));
        chk_eq("abort_no_write", 32'(enw_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
